// File: rtl/lcd_font_map_pkg.sv
// lcd_font_map_pkg
// Shared types, panel constants and the 8x8 font used by the OLED text
// renderer. Font bytes are stored one per pixel row. Bit 0 of each byte is
// the leftmost pixel.
// No ports; imported by the renderer, its interface and the scan counter.
package lcd_font_map_pkg;

  typedef logic [15:0] rgb565_t;

  // glyph_t index order is [row][bit]; text_string_t is [char][row][bit],
  // char 0 is the leftmost character of the request.
  typedef logic [7:0][7:0]      glyph_t;
  typedef logic [2:0][7:0][7:0] text_string_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_WIN    = 2'd2,
    S_PIX    = 2'd3
  } render_state_e;

  localparam int PANEL_COLS   = 96;
  localparam int PANEL_ROWS   = 64;
  localparam int WIN_X_W      = $clog2(PANEL_COLS);
  localparam int WIN_Y_W      = $clog2(PANEL_ROWS);
  localparam int MAX_CHAR_COL = 9;

  localparam rgb565_t FG_DEFAULT = 16'hFFFF;
  localparam rgb565_t BG_COLOR   = 16'h0000;

  localparam logic [23:0] TEXT_GO  = 24'h474F20;
  localparam logic [23:0] TEXT_ERS = 24'h455253;

  // Concatenations list row 7 first so that g[0] is the top pixel row.
  function automatic glyph_t char_glyph(input logic [7:0] ch);
    glyph_t g;
    g = '0;
    case (ch)
      8'h47:   g = {8'h00, 8'h7C, 8'h66, 8'h73, 8'h03, 8'h03, 8'h66, 8'h3C}; // G
      8'h4F:   g = {8'h00, 8'h1C, 8'h36, 8'h63, 8'h63, 8'h63, 8'h36, 8'h1C}; // O
      8'h45:   g = {8'h00, 8'h7F, 8'h46, 8'h16, 8'h1E, 8'h16, 8'h46, 8'h7F}; // E
      8'h52:   g = {8'h00, 8'h67, 8'h66, 8'h36, 8'h3E, 8'h66, 8'h66, 8'h3F}; // R
      8'h53:   g = {8'h00, 8'h1E, 8'h33, 8'h38, 8'h0E, 8'h07, 8'h33, 8'h1E}; // S
      default: g = '0;                                                       // space
    endcase
    return g;
  endfunction

  // Only whole three-character codes are recognised, not individual letters.
  function automatic logic text_known(input logic [23:0] text);
    return (text == TEXT_GO) || (text == TEXT_ERS);
  endfunction

  function automatic text_string_t lookup_text(input logic [23:0] text);
    text_string_t t;
    t = '0;
    if (text_known(text)) begin
      t[0] = char_glyph(text[23:16]);
      t[1] = char_glyph(text[15:8]);
      t[2] = char_glyph(text[7:0]);
    end
    return t;
  endfunction

endpackage

// File: rtl/oled_text_renderer_if.sv
// oled_text_renderer_if
// Groups the request, window-command and pixel-stream channels of the text
// renderer, plus its busy/error status.
//   slave  : renderer side (drives o_*)
//   master : requester / panel side (drives i_*)
interface oled_text_renderer_if;
  import lcd_font_map_pkg::*;

  logic                 i_req_valid;
  logic                 o_req_ready;
  logic [23:0]          i_req_text;
  logic [3:0]           i_req_col;
  logic [2:0]           i_req_row;
  rgb565_t              i_req_fg;

  logic                 o_win_valid;
  logic                 i_win_ready;
  logic [WIN_X_W-1:0]   o_win_x0;
  logic [WIN_X_W-1:0]   o_win_x1;
  logic [WIN_Y_W-1:0]   o_win_y0;
  logic [WIN_Y_W-1:0]   o_win_y1;

  logic                 o_pix_valid;
  logic                 i_pix_ready;
  rgb565_t              o_pix_data;
  logic                 o_pix_last;

  logic                 o_busy;
  logic                 o_err;

  modport slave (
    input  i_req_valid, i_req_text, i_req_col, i_req_row, i_req_fg,
    input  i_win_ready, i_pix_ready,
    output o_req_ready, o_win_valid, o_win_x0, o_win_x1, o_win_y0, o_win_y1,
    output o_pix_valid, o_pix_data, o_pix_last, o_busy, o_err
  );

  modport master (
    output i_req_valid, i_req_text, i_req_col, i_req_row, i_req_fg,
    output i_win_ready, i_pix_ready,
    input  o_req_ready, o_win_valid, o_win_x0, o_win_x1, o_win_y0, o_win_y1,
    input  o_pix_valid, o_pix_data, o_pix_last, o_busy, o_err
  );

endinterface

// File: rtl/oled_pixel_scan_counter.sv
// oled_pixel_scan_counter
// Nested bit (0..7) / character (0..2) / row (0..7) counter that walks the
// 24x8 text window in panel raster order.
//   clk_i, rst_ni : clock, async active-low reset
//   start_i       : clear all indices to zero (takes priority over adv_i)
//   adv_i         : step to the next pixel
//   bit_o, char_o, row_o : current pixel indices
//   last_o        : current pixel is the final one (row 7, char 2, bit 7)
module oled_pixel_scan_counter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       adv_i,
  output logic [2:0] bit_o,
  output logic [1:0] char_o,
  output logic [2:0] row_o,
  output logic       last_o
);

  logic [2:0] bit_q,  bit_d;
  logic [1:0] char_q, char_d;
  logic [2:0] row_q,  row_d;

  always_comb begin
    bit_d  = bit_q;
    char_d = char_q;
    row_d  = row_q;
    if (start_i) begin
      bit_d  = '0;
      char_d = '0;
      row_d  = '0;
    end else if (adv_i) begin
      if (bit_q == 3'd7) begin
        bit_d = '0;
        if (char_q == 2'd2) begin
          char_d = '0;
          row_d  = row_q + 3'd1;
        end else begin
          char_d = char_q + 2'd1;
        end
      end else begin
        bit_d = bit_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_q  <= '0;
      char_q <= '0;
      row_q  <= '0;
    end else begin
      bit_q  <= bit_d;
      char_q <= char_d;
      row_q  <= row_d;
    end
  end

  assign bit_o  = bit_q;
  assign char_o = char_q;
  assign row_o  = row_q;
  assign last_o = (row_q == 3'd7) && (char_q == 2'd2) && (bit_q == 3'd7);

endmodule

// File: rtl/oled_text_renderer.sv
// oled_text_renderer
// Takes one 3-character text request, resolves the glyphs, issues a 24x8
// window command and streams 192 RGB565 pixels in panel raster order.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus (slave)    : request channel, window command channel, pixel channel,
//                    busy and one-cycle error pulse
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | ready for a request; illegal column is rejected here
// S_LOOKUP | glyph buffer loaded from the font, window coordinates built
// S_WIN    | window command held valid until accepted
// S_PIX    | pixel stream, one pixel per handshake, leaves after pixel 191
module oled_text_renderer
  import lcd_font_map_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  oled_text_renderer_if.slave  bus
);

  render_state_e       state_q;
  logic [23:0]         text_q;
  logic [3:0]          col_q;
  logic [2:0]          row_q;
  rgb565_t             fg_q;
  text_string_t        glyph_q;

  logic                req_ready_q;
  logic                busy_q;
  logic                err_q;
  logic                win_valid_q;
  logic                pix_valid_q;
  logic [WIN_X_W-1:0]  win_x0_q, win_x1_q;
  logic [WIN_Y_W-1:0]  win_y0_q, win_y1_q;

  logic       req_hs, win_hs, pix_hs;
  logic       scan_start;
  logic [2:0] scan_bit;
  logic [1:0] scan_char;
  logic [2:0] scan_row;
  logic       scan_last;
  logic       pix_bit;

  assign req_hs     = bus.i_req_valid & req_ready_q;
  assign win_hs     = win_valid_q & bus.i_win_ready;
  assign pix_hs     = pix_valid_q & bus.i_pix_ready;
  assign scan_start = (state_q == S_WIN) & win_hs;

  oled_pixel_scan_counter u_scan (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .start_i (scan_start),
    .adv_i   (pix_hs),
    .bit_o   (scan_bit),
    .char_o  (scan_char),
    .row_o   (scan_row),
    .last_o  (scan_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      text_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      fg_q        <= '0;
      glyph_q     <= '0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      win_valid_q <= 1'b0;
      pix_valid_q <= 1'b0;
      win_x0_q    <= '0;
      win_x1_q    <= '0;
      win_y0_q    <= '0;
      win_y1_q    <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_hs) begin
            text_q <= bus.i_req_text;
            col_q  <= bus.i_req_col;
            row_q  <= bus.i_req_row;
            fg_q   <= (bus.i_req_fg == '0) ? FG_DEFAULT : bus.i_req_fg;
            if (bus.i_req_col > 4'(MAX_CHAR_COL)) begin
              err_q <= 1'b1;
            end else begin
              // Registered here so the unknown-code pulse lands in LOOKUP.
              err_q       <= ~text_known(bus.i_req_text);
              req_ready_q <= 1'b0;
              busy_q      <= 1'b1;
              state_q     <= S_LOOKUP;
            end
          end
        end
        S_LOOKUP: begin
          glyph_q     <= lookup_text(text_q);
          win_x0_q    <= {col_q, 3'b000};
          win_x1_q    <= {col_q, 3'b000} + 7'd23;
          win_y0_q    <= {row_q, 3'b000};
          win_y1_q    <= {row_q, 3'b000} + 6'd7;
          win_valid_q <= 1'b1;
          state_q     <= S_WIN;
        end
        S_WIN: begin
          if (win_hs) begin
            win_valid_q <= 1'b0;
            pix_valid_q <= 1'b1;
            state_q     <= S_PIX;
          end
        end
        S_PIX: begin
          if (pix_hs && scan_last) begin
            pix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Pixel data is decoded from registered state only, so it holds steady
  // while the stream is stalled.
  assign pix_bit = glyph_q[scan_char][scan_row][scan_bit];

  assign bus.o_req_ready = req_ready_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_err       = err_q;
  assign bus.o_win_valid = win_valid_q;
  assign bus.o_win_x0    = win_x0_q;
  assign bus.o_win_x1    = win_x1_q;
  assign bus.o_win_y0    = win_y0_q;
  assign bus.o_win_y1    = win_y1_q;
  assign bus.o_pix_valid = pix_valid_q;
  assign bus.o_pix_data  = (pix_valid_q && pix_bit) ? fg_q : BG_COLOR;
  assign bus.o_pix_last  = pix_valid_q & scan_last;

endmodule
